mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, SHALL set the maximum number of consecutive grant cycles per requester (legal range 1..15).
REQ-002 clk  input  1  rising-edge clock; the block SHALL use a single clock domain.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req  input  4  request lines; bit i belongs to requester i.
REQ-005 a, b, c, d  input  1 each  data bits of requesters 0..3.
REQ-006 grant  output  4  one-hot grant, registered; all zeros when idle.
REQ-007 sel  output  2  mux select of the granted requester, registered.
REQ-008 out  output  1  registered copy of the selected data bit.
REQ-009 valid  output  1  high when out carries data from a requester whose req was still high.
REQ-010 busy  output  1  high while the FSM is in GRANT.

Function
REQ-011 FSM states SHALL be IDLE and GRANT only.
REQ-012 IDLE with req==0 SHALL stay in IDLE; IDLE with req!=0 SHALL load grant/sel at the next edge and enter GRANT.
REQ-013 Winner SHALL be the first set req bit when searching ptr, ptr+1, ... modulo 4 (round robin); ptr SHALL reset to 0.
REQ-014 After each release, ptr SHALL become (sel+1) mod 4.
REQ-015 In GRANT, burst counter cnt SHALL increment each cycle and reset to 0 on every new grant.
REQ-016 Release SHALL occur at the edge where req[sel]==0 or cnt==MAX_BURST-1.
REQ-017 On release with other req bits set, the next winner SHALL be granted at the same edge (no idle bubble).
REQ-018 On release with req==0, the FSM SHALL return to IDLE with grant=0; sel SHALL hold its last value.
REQ-019 If only the releasing requester still requests at burst limit, it SHALL be re-granted with cnt=0.
REQ-020 out SHALL equal the mux of {a,b,c,d} by sel sampled one cycle earlier; valid SHALL equal (grant!=0 && req[sel]) sampled one cycle earlier.
REQ-021 Latency: req rising at edge N SHALL give grant at N+1 and valid/out at N+2 (from IDLE).
REQ-022 grant SHALL never have more than one bit set.
REQ-023 Requests arriving for a non-granted requester during a burst SHALL be held off without loss as long as req stays high.

Reset
REQ-024 With rst high at an edge: state=IDLE, grant=0, sel=0, out=0, valid=0, busy=0, cnt=0, ptr=0, all at that edge.
REQ-025 rst mid-burst SHALL abort the burst; arbitration after rst SHALL restart from ptr=0.

Configuration
REQ-026 With MUX_ARB_BURST_EN defined, bursts SHALL follow REQ-015/REQ-016 with MAX_BURST.
REQ-027 Without MUX_ARB_BURST_EN, the effective burst length SHALL be 1: every grant lasts one cycle, cnt logic SHALL be absent and MAX_BURST ignored.

Structure
REQ-028 A shared package mux_arb_pkg SHALL hold N_REQ=4, SEL_W=2 and the state enum (IDLE, GRANT).
REQ-029 The data path SHALL instantiate the existing mux4_1 sub-module, driven by sel; no other sub-modules.

Verification
REQ-030 Reset: assert rst 2 cycles with req=4'b1111 -> grant=0, sel=0, out=0, valid=0, busy=0; after release grant=4'b0001 one cycle later.
REQ-031 Single requester: req=4'b0100, c=1 held 6 cycles, burst enabled -> grant=4'b0100 at N+1, valid=1/out=1 from N+2, re-grant of requester 2 after 4 cycles with no gap.
REQ-032 Round robin: req=4'b1111 continuous, a=1,b=0,c=1,d=0 -> grant order 0,1,2,3,0, each held MAX_BURST cycles (1 cycle when macro undefined).
REQ-033 Early drop: requester 1 granted, req[1] falls after 2 cycles with req[3]=1 -> grant switches to 4'b1000 at the same edge, no idle cycle.
REQ-034 Reset mid-burst: rst during a requester-2 burst -> outputs zero next edge; with req=4'b1100 after reset, requester 2 granted first.
REQ-035 Invariant checks every cycle: grant one-hot or zero; busy==(grant!=0); sel matches grant index when busy.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Widths, FSM state enum and the rotating-priority pick.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // First set request at or after ptr, wrapping modulo N_REQ.
  function automatic logic [SEL_W-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [SEL_W-1:0] ptr
  );
    logic [SEL_W-1:0] idx;
    rr_pick = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [N_REQ-1:0] onehot(
    input logic [SEL_W-1:0] idx
  );
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/mux_arbiter_mux4_1.sv
// Four-to-one single-bit data mux for the arbiter data path.
// Purely combinational; sel picks d0..d3.
module mux4_1
  import mux_arb_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             d0,
  input  logic             d1,
  input  logic             d2,
  input  logic             d3,
  output logic             y
);

  always_comb begin
    y = 1'b0;
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
    endcase
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin 4-way arbiter driving a registered data mux.
// Define MUX_ARB_BURST_EN for MAX_BURST-cycle bursts; else 1-cycle grants.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             out,
  output logic             valid,
  output logic             busy
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
    $error("MAX_BURST must be within 1..15");
  end

  state_t           state, state_nx;
  logic [N_REQ-1:0] grant_nx;
  logic [SEL_W-1:0] sel_nx;
  logic [SEL_W-1:0] ptr, ptr_nx;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] win;
  logic             last;
  logic             rel;
  logic             mux_y;

`ifdef MUX_ARB_BURST_EN
  logic [CNT_W-1:0] cnt, cnt_nx;
  assign last = (cnt == CNT_W'(MAX_BURST - 1));
`else
  assign last = 1'b1;
`endif

  assign rel      = !req[sel] || last;
  assign pick_ptr = (state == GRANT) ? sel + 2'd1 : ptr;
  assign win      = rr_pick(req, pick_ptr);
  assign busy     = (state == GRANT);

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    sel_nx   = sel;
    ptr_nx   = ptr;
`ifdef MUX_ARB_BURST_EN
    cnt_nx   = cnt;
`endif
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nx = GRANT;
          grant_nx = onehot(win);
          sel_nx   = win;
`ifdef MUX_ARB_BURST_EN
          cnt_nx   = '0;
`endif
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_nx = sel + 2'd1;
          if (|req) begin
            grant_nx = onehot(win);
            sel_nx   = win;
`ifdef MUX_ARB_BURST_EN
            cnt_nx   = '0;
`endif
          end else begin
            state_nx = IDLE;
            grant_nx = '0;
          end
        end else begin
`ifdef MUX_ARB_BURST_EN
          cnt_nx = cnt + 1'b1;
`endif
        end
      end
    endcase
  end

  mux4_1 u_mux (
    .sel (sel),
    .d0  (a),
    .d1  (b),
    .d2  (c),
    .d3  (d),
    .y   (mux_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      sel   <= '0;
      ptr   <= '0;
      out   <= 1'b0;
      valid <= 1'b0;
`ifdef MUX_ARB_BURST_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      sel   <= sel_nx;
      ptr   <= ptr_nx;
      out   <= mux_y;
      valid <= (|grant) && req[sel];
`ifdef MUX_ARB_BURST_EN
      cnt   <= cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: reference model feeds a queue.
// Burst length follows MUX_ARB_BURST_EN like the design.
module tb_mux_arbiter;

  localparam int MB = 4;
`ifdef MUX_ARB_BURST_EN
  localparam int B = MB;
`else
  localparam int B = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       a = 0, b = 0, c = 0, d = 0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       out, valid, busy;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] m_grant = '0;
  logic [1:0] m_sel = '0;
  logic [1:0] m_ptr = '0;
  logic       m_out = 0, m_valid = 0;
  int         m_cnt = 0;

  logic [8:0] sbq[$];

  mux_arbiter #(.MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .grant (grant),
    .sel   (sel),
    .out   (out),
    .valid (valid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] pick(input logic [3:0] r,
                                      input logic [1:0] p);
    logic [1:0] k;
    for (int i = 0; i < 4; i++) begin
      k = p + 2'(i);
      if (r[k]) return k;
    end
    return p;
  endfunction

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++)
      if (g[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_update();
    logic [3:0] dat;
    logic       n_out, n_valid;
    logic [1:0] w;
    dat = {d, c, b, a};
    if (rst) begin
      m_grant = '0; m_sel = '0; m_ptr = '0;
      m_out = 0; m_valid = 0; m_cnt = 0;
    end else begin
      n_out   = dat[m_sel];
      n_valid = (m_grant != 0) && req[m_sel];
      if (m_grant == 0) begin
        if (req != 0) begin
          w = pick(req, m_ptr);
          m_grant = 4'b1 << w; m_sel = w; m_cnt = 0;
        end
      end else if (!req[m_sel] || m_cnt == B - 1) begin
        m_ptr = m_sel + 2'd1;
        if (req != 0) begin
          w = pick(req, m_ptr);
          m_grant = 4'b1 << w; m_sel = w; m_cnt = 0;
        end else begin
          m_grant = '0;
        end
      end else begin
        m_cnt++;
      end
      m_out = n_out;
      m_valid = n_valid;
    end
  endtask

  task automatic step();
    logic [8:0] e;
    @(posedge clk);
    model_update();
    sbq.push_back({m_grant, m_sel, m_out, m_valid, m_grant != 0});
    @(negedge clk);
    e = sbq.pop_front();
    check("grant", grant, e[8:5]);
    check("sel",   sel,   e[4:3]);
    check("out",   out,   e[2]);
    check("valid", valid, e[1]);
    check("busy",  busy,  e[0]);
    check("onehot0", $onehot0(grant), 1);
    check("busy_eq", busy, |grant);
    if (busy) check("sel_idx", sel, idx_of(grant));
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) step();
    rst = 0;
  endtask

  initial begin
    // reset with all requesting
    req = 4'b1111;
    do_reset(2);
    check("rst_grant", grant, 0);
    check("rst_sel", sel, 0);
    check("rst_out", out, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    step();
    check("post_rst_grant", grant, 4'b0001);
    req = 4'b0000;
    repeat (3) step();

    // single requester 2 with c=1
    do_reset(1);
    req = 4'b0100; c = 1;
    step();
    check("single_grant_n1", grant, 4'b0100);
    check("single_valid_n1", valid, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("single_grant", grant, 4'b0100);
      check("single_valid", valid, 1);
      check("single_out", out, 1);
    end
    req = 4'b0000; c = 0;
    repeat (3) step();
    check("single_idle_grant", grant, 0);
    check("single_idle_sel", sel, 2'd2);

    // round robin, all requesting
    do_reset(1);
    req = 4'b1111; a = 1; b = 0; c = 1; d = 0;
    for (int k = 0; k <= 4 * B; k++) begin
      step();
      check("rr_grant", grant, 4'b1 << ((k / B) % 4));
    end
    req = 4'b0000;
    repeat (3) step();

    // early drop of requester 1 with requester 3 waiting
    do_reset(1);
    req = 4'b0010;
    step();
    check("drop_g1", grant, 4'b0010);
    step();
    req = 4'b1000;
    step();
    check("drop_g3", grant, 4'b1000);
    check("drop_busy", busy, 1);
    req = 4'b0000;
    repeat (3) step();

    // reset in the middle of a requester-2 burst
    do_reset(1);
    req = 4'b0100; c = 1;
    step();
    step();
    rst = 1;
    step();
    check("midrst_grant", grant, 0);
    check("midrst_valid", valid, 0);
    check("midrst_out", out, 0);
    rst = 0;
    req = 4'b1100;
    step();
    check("midrst_first", grant, 4'b0100);
    req = 4'b0000;
    repeat (3) step();

    // random traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      {a, b, c, d} = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
